// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART TX among NUM_REQ byte streams.
// Grant 1 cycle after request, strobe 1 cycle after handshake; req_ready held low while the UART is busy.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_GAP = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESETN,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       o_tx_dv,
    output logic [7:0]                 o_tx_byte,
    input  logic                       i_tx_active,
    input  logic                       i_tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_vld,
    output logic                       timeout,
    output logic [CNT_W-1:0]           tx_count
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(MAX_GAP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              last_q, last_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [ID_W-1:0]   grant_id_nxt, pick;
    logic              grant_vld_nxt, dv_nxt, timeout_nxt;
    logic [7:0]        byte_nxt, sel_data;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              sel_valid, sel_last, hs;

    assign sel_data  = req_data[{grant_id, 3'b000} +: 8];
    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];

    // Scan upward starting one past the previous winner so every requester gets a turn.
    always_comb begin
        logic            found;
        logic [ID_W-1:0] cand;
        pick  = grant_id;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(grant_id) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state     <= IDLE;
            grant_id  <= ID_W'(NUM_REQ - 1);
            grant_vld <= 1'b0;
            o_tx_dv   <= 1'b0;
            o_tx_byte <= '0;
            last_q    <= 1'b0;
            tx_count  <= '0;
            gap_cnt   <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_id_nxt;
            grant_vld <= grant_vld_nxt;
            o_tx_dv   <= dv_nxt;
            o_tx_byte <= byte_nxt;
            last_q    <= last_nxt;
            tx_count  <= cnt_nxt;
            gap_cnt   <= gap_nxt;
            timeout   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_id_nxt  = grant_id;
        grant_vld_nxt = grant_vld;
        dv_nxt        = 1'b0;
        byte_nxt      = o_tx_byte;
        last_nxt      = last_q;
        cnt_nxt       = tx_count;
        gap_nxt       = gap_cnt;
        timeout_nxt   = 1'b0;
        req_ready     = '0;
        hs            = 1'b0;

        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_id_nxt  = pick;
                    grant_vld_nxt = 1'b1;
                    gap_nxt       = '0;
                    state_nxt     = SEND;
                end
            end
            SEND: begin
                hs                  = sel_valid & ~i_tx_active;
                req_ready[grant_id] = hs;
                if (hs) begin
                    byte_nxt  = sel_data;
                    last_nxt  = sel_last;
                    dv_nxt    = 1'b1;
                    cnt_nxt   = tx_count + CNT_W'(1);
                    state_nxt = WAIT;
                end else if (gap_cnt == GAP_W'(MAX_GAP - 1)) begin
                    // Stalled requester: drop the rest of its message and re-arbitrate.
                    timeout_nxt   = 1'b1;
                    grant_vld_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            WAIT: begin
                // A done pulse coinciding with our own strobe belongs to an earlier byte.
                if (i_tx_done && !o_tx_dv) begin
                    if (last_q) begin
                        grant_vld_nxt = 1'b0;
                        state_nxt     = IDLE;
                    end else begin
                        gap_nxt   = '0;
                        state_nxt = SEND;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues, a UART model, expected-byte queue.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int GAP  = 16;
    localparam int CW   = 16;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] dat;
    } exp_t;

    logic              clk = 1'b0;
    logic              arst_n;
    logic [NREQ-1:0]   req_valid, req_last, req_ready;
    logic [NREQ*8-1:0] req_data;
    logic              tx_dv, tx_active, tx_done, model_active, force_active;
    logic [7:0]        tx_byte;
    logic [1:0]        grant_id;
    logic              grant_vld, timeout;
    logic [CW-1:0]     tx_count;
    logic [NREQ-1:0]   hs_q = '0;

    logic [8:0] rq [NREQ][$];
    exp_t       sb [$];
    logic [1:0] grants [$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, dv_cnt = 0, done_cnt = 0, to_cnt = 0;
    int done_cyc = 0, to_cyc = 0, mcnt = 0;
    logic to_gvld = 1'b0, gv_prev = 1'b0;

    always #5 clk = ~clk;
    assign tx_active = model_active | force_active;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .MAX_GAP(GAP), .CNT_W(CW)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(arst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .o_tx_dv      (tx_dv),
        .o_tx_byte    (tx_byte),
        .i_tx_active  (tx_active),
        .i_tx_done    (tx_done),
        .grant_id     (grant_id),
        .grant_vld    (grant_vld),
        .timeout      (timeout),
        .tx_count     (tx_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input int id, input logic last, input logic [7:0] dat);
        rq[id].push_back({last, dat});
    endtask

    task automatic expect_byte(input int id, input logic [7:0] dat);
        exp_t e;
        e.id  = 8'(id);
        e.dat = dat;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        arst_n       = 1'b0;
        force_active = 1'b0;
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        sb.delete();
        repeat (3) tick();
        arst_n = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (done_cnt >= target) break;
            tick();
        end
        chk(tag, 32'(done_cnt >= target), 1);
    endtask

    task automatic wait_dv(input string tag, input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (dv_cnt >= target) break;
            tick();
        end
        chk(tag, 32'(dv_cnt >= target), 1);
    endtask

    task automatic wait_to(input string tag, input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (to_cnt >= target) break;
            tick();
        end
        chk(tag, 32'(to_cnt >= target), 1);
    endtask

    // Sampled before the DUT's own nonblocking updates land, so this is the handshake of the edge.
    always @(posedge clk) hs_q <= req_valid & req_ready;

    // Requester drivers, UART model and output monitor, all stepped on the falling edge.
    initial begin
        exp_t       e;
        logic [8:0] f;
        model_active = 1'b0;
        tx_done      = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!arst_n) begin
                model_active = 1'b0;
                tx_done      = 1'b0;
                mcnt         = 0;
            end else begin
                tx_done = 1'b0;
                if (req_ready != '0) chk("ready_onehot", 32'($onehot(req_ready)), 1);
                if (tx_dv) begin
                    chk("dv_while_active", 32'(tx_active), 0);
                    dv_cnt++;
                    if (sb.size() == 0) begin
                        chk("unexpected_strobe", 32'(tx_byte), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("tx_byte", 32'(tx_byte), 32'(e.dat));
                        chk("tx_id", 32'(grant_id), 32'(e.id));
                    end
                    model_active = 1'b1;
                    mcnt         = 20;
                end else if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        tx_done      = 1'b1;
                        model_active = 1'b0;
                        done_cnt++;
                        done_cyc = cyc;
                    end
                end
            end
            if (timeout) begin
                to_cnt++;
                to_cyc  = cyc;
                to_gvld = grant_vld;
            end
            if (grant_vld && !gv_prev) grants.push_back(grant_id);
            gv_prev = grant_vld;
            for (int i = 0; i < NREQ; i++) begin
                if (hs_q[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    f                  = rq[i][0];
                    req_valid[i]       = 1'b1;
                    req_last[i]        = f[8];
                    req_data[i*8 +: 8] = f[7:0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    initial begin
        int n0, d0, t0, g0;
        arst_n       = 1'b0;
        force_active = 1'b0;

        // Reset values and quiet idle
        repeat (3) tick();
        arst_n = 1'b1;
        tick();
        chk("rst_grant_vld", 32'(grant_vld), 0);
        chk("rst_tx_dv", 32'(tx_dv), 0);
        chk("rst_tx_count", 32'(tx_count), 0);
        chk("rst_grant_id", 32'(grant_id), 3);
        chk("rst_timeout", 32'(timeout), 0);
        d0 = dv_cnt;
        repeat (10) tick();
        chk("idle_no_strobe", 32'(dv_cnt - d0), 0);

        // Single two-byte message from requester 2
        push(2, 1'b0, 8'h48); push(2, 1'b1, 8'h69);
        expect_byte(2, 8'h48); expect_byte(2, 8'h69);
        n0 = done_cnt;
        wait_done("msg_wait", n0 + 2, 200);
        chk("msg_gvld_at_done", 32'(grant_vld), 1);
        tick();
        chk("msg_gvld_after", 32'(grant_vld), 0);
        chk("msg_tx_count", 32'(tx_count), 2);
        chk("msg_sb_drained", 32'(sb.size()), 0);

        // Round-robin among 0, 1, 3 with requester 0 queuing a second message
        do_reset();
        g0 = grants.size();
        push(0, 1'b0, 8'h10); push(0, 1'b1, 8'h11);
        push(0, 1'b0, 8'h12); push(0, 1'b1, 8'h13);
        push(1, 1'b0, 8'h20); push(1, 1'b1, 8'h21);
        push(3, 1'b0, 8'h30); push(3, 1'b1, 8'h31);
        expect_byte(0, 8'h10); expect_byte(0, 8'h11);
        expect_byte(1, 8'h20); expect_byte(1, 8'h21);
        expect_byte(3, 8'h30); expect_byte(3, 8'h31);
        expect_byte(0, 8'h12); expect_byte(0, 8'h13);
        n0 = done_cnt;
        wait_done("rr_wait", n0 + 8, 1000);
        tick();
        chk("rr_grant_count", 32'(grants.size() - g0), 4);
        if (grants.size() >= g0 + 4) begin
            chk("rr_grant0", 32'(grants[g0]), 0);
            chk("rr_grant1", 32'(grants[g0+1]), 1);
            chk("rr_grant2", 32'(grants[g0+2]), 3);
            chk("rr_grant3", 32'(grants[g0+3]), 0);
        end
        chk("rr_tx_count", 32'(tx_count), 8);
        chk("rr_sb_drained", 32'(sb.size()), 0);

        // Watchdog: requester 1 stalls mid-message, requester 2 waits behind it
        do_reset();
        g0 = grants.size();
        t0 = to_cnt;
        n0 = done_cnt;
        push(1, 1'b0, 8'hAA);
        push(2, 1'b1, 8'h55);
        expect_byte(1, 8'hAA); expect_byte(2, 8'h55);
        wait_to("wd_wait", t0 + 1, 300);
        chk("wd_delay", 32'(to_cyc - done_cyc), 17);
        chk("wd_gvld", 32'(to_gvld), 0);
        wait_done("wd_next_wait", n0 + 2, 300);
        chk("wd_single_pulse", 32'(to_cnt - t0), 1);
        chk("wd_grant_count", 32'(grants.size() - g0), 2);
        if (grants.size() >= g0 + 2) chk("wd_next_grant", 32'(grants[g0+1]), 2);
        chk("wd_sb_drained", 32'(sb.size()), 0);

        // UART busy holds off the handshake
        do_reset();
        force_active = 1'b1;
        push(0, 1'b1, 8'h77);
        expect_byte(0, 8'h77);
        d0 = dv_cnt;
        n0 = done_cnt;
        repeat (5) tick();
        chk("busy_gvld", 32'(grant_vld), 1);
        chk("busy_ready", 32'(req_ready), 0);
        chk("busy_no_dv", 32'(dv_cnt - d0), 0);
        force_active = 1'b0;
        #1;
        chk("busy_ready_rel", 32'(req_ready), 1);
        tick();
        chk("busy_dv", 32'(tx_dv), 1);
        chk("busy_dv_cnt", 32'(dv_cnt - d0), 1);
        wait_done("busy_done_wait", n0 + 1, 100);

        // Reset while the first of three bytes is in flight
        do_reset();
        push(0, 1'b0, 8'h01); push(0, 1'b0, 8'h02); push(0, 1'b1, 8'h03);
        expect_byte(0, 8'h01);
        d0 = dv_cnt;
        wait_dv("mid_dv_wait", d0 + 1, 100);
        repeat (3) tick();
        chk("mid_in_wait", 32'(grant_vld), 1);
        arst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        #1;
        chk("mid_rst_gvld", 32'(grant_vld), 0);
        chk("mid_rst_dv", 32'(tx_dv), 0);
        chk("mid_rst_byte", 32'(tx_byte), 0);
        chk("mid_rst_count", 32'(tx_count), 0);
        chk("mid_rst_gid", 32'(grant_id), 3);
        chk("mid_rst_ready", 32'(req_ready), 0);
        repeat (3) tick();
        arst_n = 1'b1;
        d0 = dv_cnt;
        repeat (10) tick();
        chk("mid_post_quiet", 32'(dv_cnt - d0), 0);
        push(3, 1'b1, 8'h99);
        expect_byte(3, 8'h99);
        n0 = done_cnt;
        wait_dv("mid_new_dv", d0 + 1, 100);
        tick();
        chk("mid_count_restart", 32'(tx_count), 1);
        wait_done("mid_new_done", n0 + 1, 100);
        chk("mid_sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "bench time limit");
    end
endmodule
